// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: responder FSM state
// encoding, word/byte-lane geometry and the address legality check.
package dmem_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Misaligned, or beyond the last stored word. The whole address is compared,
  // so any set bit above the index range is an error rather than an alias.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned depth_words);
    logic [WORD_W+1:0] lim;
    lim = (WORD_W + 2)'(depth_words) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= lim);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage for the data-memory responder.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset; clears every word and the read register
//   we_i     write strobe; be_i selects the byte lanes of wdata_i written to word idx_i
//   re_i     read strobe; word idx_i is registered into rdata_o
//   rdata_o  registered read data, held until the next read
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 128,
  localparam int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [LANES-1:0]  be_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        for (int unsigned n = 0; n < LANES; n++) begin
          if (be_i[n]) begin
            mem_q[idx_i][n*BYTE_W +: BYTE_W] <= wdata_i[n*BYTE_W +: BYTE_W];
          end
        end
      end
      if (re_i) begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory target for the CPU memory stage. Accepts one
// load/store at a time, inserts LATENCY wait states, commits the access on the
// edge that enters the response state and reports misaligned/out-of-range
// requests as errors.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   req_write_i               1 = store, 0 = load
//   req_addr_i                byte address
//   req_wdata_i, req_be_i     store data and byte enables
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_rdata_o               load data (0 for stores and errors)
//   rsp_err_o                 request was misaligned or out of range
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q;
  logic [WORD_W-1:0]  addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic [LANES-1:0]   be_q;

  logic               accept;
  logic               enter_resp;
  logic               sel_write;
  logic [WORD_W-1:0]  sel_addr;
  logic [WORD_W-1:0]  sel_wdata;
  logic [LANES-1:0]   sel_be;
  logic               sel_err;
  logic               rsp_err;
  logic [WORD_W-1:0]  arr_rdata;

  assign accept = req_valid_i & req_ready_o;

  // State register and captured request fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With LATENCY=0 the commit edge is the acceptance edge itself, so the
  // request fields come straight from the inputs in IDLE and from the
  // captured copy otherwise.
  always_comb begin
    sel_write  = (state_q == ST_IDLE) ? req_write_i : write_q;
    sel_addr   = (state_q == ST_IDLE) ? req_addr_i  : addr_q;
    sel_wdata  = (state_q == ST_IDLE) ? req_wdata_i : wdata_q;
    sel_be     = (state_q == ST_IDLE) ? req_be_i    : be_q;
    sel_err    = addr_err(sel_addr, DEPTH_WORDS);
    enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    rsp_err    = addr_err(addr_q, DEPTH_WORDS);
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (enter_resp & sel_write & ~sel_err),
    .be_i    (sel_be),
    .idx_i   (sel_addr[IDX_W+1:2]),
    .wdata_i (sel_wdata),
    .re_i    (enter_resp & ~sel_write & ~sel_err),
    .rdata_o (arr_rdata)
  );

  // Outputs. The array read register only changes on a commit, so load data
  // stays frozen for as long as the response is back-pressured.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE) & ~rst_i;
    rsp_valid_o = (state_q == ST_RESP);
    rsp_err_o   = (state_q == ST_RESP) & rsp_err;
    rsp_rdata_o = '0;
    if ((state_q == ST_RESP) && !write_q && !rsp_err) begin
      rsp_rdata_o = arr_rdata;
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Handshaked data-memory target that services load/store requests from the CPU's memory stage.
- Adds a configurable number of wait states, byte-lane writes and error reporting.
- Replaces the zero-latency data memory so the datapath can later be run against a realistic, multi-cycle memory.
- Sits between the CPU memory-stage request logic and word-organised storage.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words stored; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
LATENCY, 2, wait-state cycles between request acceptance and response; 0 is legal.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous reset, active-high.
req_valid_i  in  1  request present.
req_ready_o  out  1  responder can accept a request.
req_write_i  in  1  1 = store, 0 = load.
req_addr_i  in  32  byte address.
req_wdata_i  in  32  store data.
req_be_i  in  4  byte enables for stores; bit n enables wdata[8n+7:8n].
rsp_valid_o  out  1  response present.
rsp_ready_i  in  1  requester accepts the response.
rsp_rdata_o  out  32  load data; 0 for stores and for errors.
rsp_err_o  out  1  request was misaligned or out of range.

Behaviour:
- Interface: one clock clk_i; rst_i is synchronous and active-high.
- Reset (rst_i high at an edge):
  - state goes to IDLE; req_ready_o=0 during the reset cycle, then 1.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wait counter cleared.
  - all storage words are cleared to 0.
- FSM states:
  - IDLE: req_ready_o=1, rsp_valid_o=0. On req_valid_i&req_ready_o, capture write/addr/wdata/be. Go to WAIT if LATENCY>0, else to RESP.
  - WAIT: req_ready_o=0. The counter is loaded with LATENCY on acceptance and decrements each cycle. Leave for RESP on the cycle the counter equals 1.
  - RESP: rsp_valid_o=1. rsp_rdata_o and rsp_err_o hold stable until rsp_ready_i. When rsp_valid_o&rsp_ready_i, go to IDLE; rsp_valid_o drops and rsp_* outputs clear to 0 next cycle.
- Latency:
  - A request accepted at edge T gives rsp_valid_o high from edge T+1+LATENCY.
  - No new request is accepted in the same cycle a response is consumed.
  - Throughput is at most one request per LATENCY+2 cycles.
- Access commit happens on the edge that enters RESP, exactly once:
  - load: rsp_rdata_o <= mem[addr[k+1:2]] (full word; be ignored).
  - store: for each n with be[n]=1, mem byte lane n <= wdata lane n. be=4'b0000 is a no-op that is still acknowledged.
- Error cases (addr[1:0]!=0, or addr >= 4*DEPTH_WORDS):
  - no storage access; rsp_err_o=1, rsp_rdata_o=0.
  - the response timing is identical to a legal access.
- Boundary rules:
  - Back-pressure: rsp_ready_i low holds RESP indefinitely with outputs frozen.
  - req_valid_i outside IDLE is ignored and not queued.
  - Captured request fields are registered: input changes after acceptance have no effect.
  - Reset mid-WAIT: the pending store is discarded (nothing commits); the array is cleared anyway.
  - Reset in RESP: the response is dropped.
  - The last word (addr 4*DEPTH_WORDS-4) is legal; 4*DEPTH_WORDS is an error.
  - Address bits above the index range must be zero, else error (no aliasing).

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding constants ST_IDLE, ST_WAIT, ST_RESP (2-bit).
  - byte-lane width constant (8) and word width constant (32).
- One sub-module, dmem_array:
  - DEPTH_WORDS x 32 storage with synchronous reset clear.
  - write port with 4-bit byte enables; registered read port.
  - instantiated once by the FSM top.

Test Plan:
- Reset, then store addr=0x10, wdata=0xDEADBEEF, be=4'hF; then load addr=0x10 -> each rsp_valid_o arrives exactly 3 cycles after acceptance (LATENCY=2); load rdata=0xDEADBEEF, err=0.
- Store addr=0x10, wdata=0x000000AA, be=4'b0001 over 0xDEADBEEF, then load -> rdata=0xDEADBEAA. Then store with be=0, and load -> unchanged.
- Load addr=0x13 (misaligned) and load addr=0x200 (DEPTH=128) -> err=1, rdata=0, same 3-cycle latency; a later load of 0x1FC -> err=0.
- Hold rsp_ready_i low for 5 cycles in RESP while driving req_valid_i with a new store -> rsp_valid_o and data stay stable, req_ready_o=0, and that store never commits.
- Assert rst_i during WAIT of a store to 0x20 with wdata=0x12345678 -> next cycle rsp_valid_o=0; after release req_ready_o=1, and a load of 0x20 returns 0.
- Rebuild with LATENCY=0: accept at T -> rsp_valid_o at T+1; back-to-back requests with rsp_ready_i tied high accepted every 2 cycles.
